v_tile: RTL and testbench

- Vector CGRA tile that holds operands in a small register file and adds them in a SIMD adder.
- Two neighbour ports each deliver a vector of num_inputs words. A third port delivers a config word.
- The config word selects the lane split (4x16b, 2x32b or 1x64b) and a destination tag.
- Sits in the tile array between neighbour tiles and the routing network, which consumes adder_outputs and dest_info.

---
 rtl/v_tile.sv | 168 ++++++++++++++++
 tb/tb_v_tile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/v_tile.sv
// Vector CGRA tile: two neighbour ports fill an operand register file, a config
// port picks the lane split, and a start edge launches one SIMD add.
module v_tile #(
  parameter int width        = 16,
  parameter int num_inputs   = 4,
  parameter int num_regs     = 16,
  parameter int total_inputs = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               on_off,
  input  logic                               write_en1,
  output logic                               write_rdy1,
  input  logic [num_inputs-1:0][width-1:0]   w_data_in1,
  output logic                               write_ack1,
  input  logic                               write_en2,
  output logic                               write_rdy2,
  input  logic [num_inputs-1:0][width-1:0]   w_data_in2,
  output logic                               write_ack2,
  input  logic                               write_en3,
  output logic                               write_rdy3,
  input  logic [width-1:0]                   w_data_in3,
  output logic                               write_ack3,
  output logic [num_inputs-1:0][width-1:0]   adder_outputs,
  output logic [3:0]                         dest_info,
  output logic                               adder_ack
);

  localparam logic [1:0] MODE_2X32 = 2'd1;
  localparam logic [1:0] MODE_1X64 = 2'd3;
  localparam int         B_BASE    = total_inputs - num_inputs;

  logic [width-1:0]                 regs_q [num_regs];
  logic [width-1:0]                 regs_d [num_regs];
  logic [1:0]                       mode_q, mode_d;
  logic [3:0]                       dest_q, dest_d;
  logic                             prev_on_q, prev_on_d;
  logic                             busy_q, busy_d;
  logic [1:0]                       cnt_q, cnt_d;
  logic [num_inputs-1:0][width-1:0] pend_q, pend_d;
  logic [num_inputs-1:0][width-1:0] out_q, out_d;
  logic                             ack_q, ack_d;
  logic                             wack1_q, wack1_d;
  logic                             wack2_q, wack2_d;
  logic                             wack3_q, wack3_d;

  logic                             ready;
  logic                             start;
  logic [num_inputs-1:0][width-1:0] sum;
  logic [1:0]                       lat_m1;
  logic                             unused_cfg;

  assign unused_cfg = ^{w_data_in3[width-1:8], w_data_in3[3:2]};

  assign ready      = reset && !busy_q;
  assign write_rdy1 = ready;
  assign write_rdy2 = ready;
  assign write_rdy3 = ready;
  assign start      = ready && on_off && !prev_on_q;

  // Segmented adder: carry may enter a 16-bit segment only when that segment
  // continues a wider lane; mode 2 (reserved) falls through to 4x16b.
  always_comb begin : seg_adder
    logic             carry;
    logic             cin;
    logic [width:0]   seg;
    carry = 1'b0;
    cin   = 1'b0;
    seg   = '0;
    sum   = '0;
    for (int i = 0; i < num_inputs; i++) begin
      if (i == 0)                   cin = 1'b0;
      else if (mode_q == MODE_1X64) cin = carry;
      else if (mode_q == MODE_2X32) cin = (i % 2 == 1) ? carry : 1'b0;
      else                          cin = 1'b0;
      seg    = {1'b0, regs_q[i]} + {1'b0, regs_q[B_BASE+i]} + {{width{1'b0}}, cin};
      sum[i] = seg[width-1:0];
      carry  = seg[width];
    end
  end

  always_comb begin
    case (mode_q)
      MODE_2X32: lat_m1 = 2'd1;
      MODE_1X64: lat_m1 = 2'd2;
      default:   lat_m1 = 2'd0;
    endcase
  end

  always_comb begin
    regs_d    = regs_q;
    mode_d    = mode_q;
    dest_d    = dest_q;
    prev_on_d = on_off;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    out_d     = out_q;
    ack_d     = ack_q;
    wack1_d   = write_en1 && ready;
    wack2_d   = write_en2 && ready;
    wack3_d   = write_en3 && ready;

    if (wack1_d)
      for (int i = 0; i < num_inputs; i++) regs_d[i] = w_data_in1[i];
    if (wack2_d)
      for (int i = 0; i < num_inputs; i++) regs_d[B_BASE+i] = w_data_in2[i];
    if (wack3_d) begin
      mode_d = w_data_in3[1:0];
      dest_d = w_data_in3[7:4];
    end

    // The sum is captured at the start edge so later writes cannot disturb it;
    // the counter only models the per-mode latency before it is published.
    if (start) begin
      busy_d = 1'b1;
      ack_d  = 1'b0;
      cnt_d  = lat_m1;
      pend_d = sum;
    end else if (busy_q) begin
      if (cnt_q == 2'd0) begin
        out_d  = pend_q;
        ack_d  = 1'b1;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < num_regs; i++) regs_q[i] <= '0;
      mode_q    <= '0;
      dest_q    <= '0;
      prev_on_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= '0;
      out_q     <= '0;
      ack_q     <= 1'b0;
      wack1_q   <= 1'b0;
      wack2_q   <= 1'b0;
      wack3_q   <= 1'b0;
    end else begin
      for (int i = 0; i < num_regs; i++) regs_q[i] <= regs_d[i];
      mode_q    <= mode_d;
      dest_q    <= dest_d;
      prev_on_q <= prev_on_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      out_q     <= out_d;
      ack_q     <= ack_d;
      wack1_q   <= wack1_d;
      wack2_q   <= wack2_d;
      wack3_q   <= wack3_d;
    end
  end

  assign adder_outputs = out_q;
  assign dest_info     = dest_q;
  assign adder_ack     = ack_q;
  assign write_ack1    = wack1_q;
  assign write_ack2    = wack2_q;
  assign write_ack3    = wack3_q;

endmodule

// File: tb/tb_v_tile.sv
// Directed bench for v_tile: loads operands and config, launches adds in each
// lane mode and compares results, latency and handshakes to hand-computed values.
module tb_v_tile;

  logic             clk;
  logic             reset;
  logic             on_off;
  logic             write_en1, write_en2, write_en3;
  logic             write_rdy1, write_rdy2, write_rdy3;
  logic             write_ack1, write_ack2, write_ack3;
  logic [3:0][15:0] w_data_in1, w_data_in2;
  logic [15:0]      w_data_in3;
  logic [3:0][15:0] adder_outputs;
  logic [3:0]       dest_info;
  logic             adder_ack;

  int checks;
  int errors;

  v_tile dut (
    .clk           (clk),
    .reset         (reset),
    .on_off        (on_off),
    .write_en1     (write_en1),
    .write_rdy1    (write_rdy1),
    .w_data_in1    (w_data_in1),
    .write_ack1    (write_ack1),
    .write_en2     (write_en2),
    .write_rdy2    (write_rdy2),
    .w_data_in2    (w_data_in2),
    .write_ack2    (write_ack2),
    .write_en3     (write_en3),
    .write_rdy3    (write_rdy3),
    .w_data_in3    (w_data_in3),
    .write_ack3    (write_ack3),
    .adder_outputs (adder_outputs),
    .dest_info     (dest_info),
    .adder_ack     (adder_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writes both operand vectors and the config word in the same cycle.
  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b,
                               input logic [15:0] cfg, input string tag);
    write_en1  = 1'b1;
    write_en2  = 1'b1;
    write_en3  = 1'b1;
    w_data_in1 = a;
    w_data_in2 = b;
    w_data_in3 = cfg;
    tick();
    write_en1 = 1'b0;
    write_en2 = 1'b0;
    write_en3 = 1'b0;
    checkOutput({tag, "_ack1"}, 64'(write_ack1), 64'd1);
    checkOutput({tag, "_ack2"}, 64'(write_ack2), 64'd1);
    checkOutput({tag, "_ack3"}, 64'(write_ack3), 64'd1);
    tick();
    checkOutput({tag, "_ack_drop"}, 64'({write_ack1, write_ack2, write_ack3}), 64'd0);
  endtask

  task automatic runAdd(input logic [63:0] exp_out, input int exp_lat, input string tag);
    int cycles;
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    checkOutput({tag, "_ack_clr"}, 64'(adder_ack), 64'd0);
    cycles = 0;
    while (!adder_ack && cycles < 10) begin
      tick();
      cycles++;
    end
    checkOutput({tag, "_lat"}, 64'(cycles), 64'(exp_lat));
    checkOutput({tag, "_out"}, adder_outputs, exp_out);
  endtask

  localparam logic [63:0] VEC_A   = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [63:0] VEC_B   = {16'd13, 16'd12, 16'd11, 16'd10};
  localparam logic [63:0] SUM_AB  = {16'd17, 16'd15, 16'd13, 16'd11};
  localparam logic [63:0] LOW_FF  = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] ONE     = 64'h0000_0000_0000_0001;
  localparam logic [63:0] ALL_FF  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NINES   = {16'd9, 16'd9, 16'd9, 16'd9};

  initial begin
    int ack_drops;
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    on_off     = 1'b0;
    write_en1  = 1'b0;
    write_en2  = 1'b0;
    write_en3  = 1'b0;
    w_data_in1 = '0;
    w_data_in2 = '0;
    w_data_in3 = '0;

    tick();
    tick();
    checkOutput("rst_out", adder_outputs, 64'd0);
    checkOutput("rst_ack", 64'(adder_ack), 64'd0);
    checkOutput("rst_dest", 64'(dest_info), 64'd0);
    checkOutput("rst_rdy", 64'({write_rdy1, write_rdy2, write_rdy3}), 64'd0);
    checkOutput("rst_wack", 64'({write_ack1, write_ack2, write_ack3}), 64'd0);

    reset = 1'b1;
    tick();
    checkOutput("rel_rdy", 64'({write_rdy1, write_rdy2, write_rdy3}), 64'h7);
    checkOutput("rel_out", adder_outputs, 64'd0);

    applyStimulus(VEC_A, VEC_B, 16'h0064, "w16");
    checkOutput("dest6", 64'(dest_info), 64'd6);
    runAdd(SUM_AB, 1, "m16");

    applyStimulus(VEC_A, VEC_B, 16'h0001, "w32");
    checkOutput("dest0", 64'(dest_info), 64'd0);
    runAdd(SUM_AB, 2, "m32");

    applyStimulus(VEC_A, VEC_B, 16'h0003, "w64");
    runAdd(SUM_AB, 3, "m64");

    applyStimulus(LOW_FF, ONE, 16'h0000, "wc16");
    runAdd(64'd0, 1, "c16");
    applyStimulus(LOW_FF, ONE, 16'h0001, "wc32");
    runAdd(64'h0000_0000_0001_0000, 2, "c32");
    applyStimulus(ALL_FF, ONE, 16'h0003, "wc64");
    runAdd(64'd0, 3, "c64");

    // Mode 2 is reserved and must split lanes like 4x16b.
    applyStimulus(LOW_FF, ONE, 16'h0002, "wres");
    runAdd(64'd0, 1, "res");

    // Busy behaviour during a 1x64b add.
    applyStimulus(VEC_A, VEC_B, 16'h0053, "wbusy");
    checkOutput("dest5", 64'(dest_info), 64'd5);
    on_off = 1'b1;
    tick();
    on_off     = 1'b0;
    write_en1  = 1'b1;
    w_data_in1 = NINES;
    checkOutput("busy_rdy1", 64'(write_rdy1), 64'd0);
    tick();
    checkOutput("busy_wack1_a", 64'(write_ack1), 64'd0);
    on_off = 1'b1;
    tick();
    checkOutput("busy_wack1_b", 64'(write_ack1), 64'd0);
    checkOutput("busy_ack_pend", 64'(adder_ack), 64'd0);
    tick();
    write_en1 = 1'b0;
    checkOutput("busy_wack1_c", 64'(write_ack1), 64'd0);
    checkOutput("busy_done", 64'(adder_ack), 64'd1);
    checkOutput("busy_out", adder_outputs, SUM_AB);
    ack_drops = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!adder_ack) ack_drops++;
    end
    checkOutput("busy_single_ack", 64'(ack_drops), 64'd0);
    on_off = 1'b0;
    tick();
    w_data_in3 = 16'h0000;
    write_en3  = 1'b1;
    tick();
    write_en3 = 1'b0;
    runAdd(SUM_AB, 1, "regs_kept");

    // Reset in the middle of a 1x64b add.
    applyStimulus(VEC_B, VEC_B, 16'h0073, "wrst");
    on_off = 1'b1;
    tick();
    on_off = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    checkOutput("mid_rst_ack", 64'(adder_ack), 64'd0);
    checkOutput("mid_rst_out", adder_outputs, 64'd0);
    checkOutput("mid_rst_dest", 64'(dest_info), 64'd0);
    reset = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("post_rst_ack", 64'(adder_ack), 64'd0);
    checkOutput("post_rst_out", adder_outputs, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
